// File: rtl/apb_pkg.sv
// apb_pkg: APB phase encoding shared by the master arbiter and the UART slave bridge.
package apb_pkg;
    typedef enum logic [1:0] {
        APB_IDLE   = 2'd0,
        APB_SETUP  = 2'd1,
        APB_ACCESS = 2'd2
    } apb_state_e;
endpackage

// File: rtl/apb_master_arb_rr_arb2.sv
// rr_arb2: combinational two-way round-robin picker; on a tie the requester not served last wins.
module rr_arb2 (
    input  logic [1:0] eligible,
    input  logic       last_grant,
    output logic       gnt_valid,
    output logic       gnt_id
);
    assign gnt_valid = |eligible;
    assign gnt_id    = (&eligible) ? ~last_grant : eligible[1];
endmodule

// File: rtl/apb_master_arb.sv
// apb_master_arb: shares one APB bus between two requesters, sequencing SETUP/ACCESS
// with round-robin arbitration, per-requester responses and a stall timeout.
module apb_master_arb
    import apb_pkg::*;
#(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                  PCLK,
    input  logic                  PRESETn,
    input  logic                  r0_valid,
    input  logic                  r0_write,
    input  logic [ADDR_WIDTH-1:0] r0_addr,
    input  logic [DATA_WIDTH-1:0] r0_wdata,
    output logic                  r0_done,
    output logic [DATA_WIDTH-1:0] r0_rdata,
    output logic                  r0_err,
    input  logic                  r1_valid,
    input  logic                  r1_write,
    input  logic [ADDR_WIDTH-1:0] r1_addr,
    input  logic [DATA_WIDTH-1:0] r1_wdata,
    output logic                  r1_done,
    output logic [DATA_WIDTH-1:0] r1_rdata,
    output logic                  r1_err,
    output logic                  PSEL,
    output logic                  PENABLE,
    output logic                  PWRITE,
    output logic [ADDR_WIDTH-1:0] PADDR,
    output logic [DATA_WIDTH-1:0] PWDATA,
    input  logic [DATA_WIDTH-1:0] PRDATA,
    input  logic                  PREADY,
    input  logic                  PSLVERR,
    output logic                  grant,
    output logic                  busy
);
    localparam int CW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

    apb_state_e            state_q, state_d;
    logic                  psel_q, psel_d, penable_q, penable_d, pwrite_q, pwrite_d;
    logic [ADDR_WIDTH-1:0] paddr_q, paddr_d;
    logic [DATA_WIDTH-1:0] pwdata_q, pwdata_d;
    logic                  grant_q, grant_d, busy_q, busy_d, last_grant_q, last_grant_d;
    logic                  r0_done_q, r0_done_d, r1_done_q, r1_done_d;
    logic                  r0_err_q, r0_err_d, r1_err_q, r1_err_d;
    logic [DATA_WIDTH-1:0] r0_rdata_q, r0_rdata_d, r1_rdata_q, r1_rdata_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic                  gnt_valid, gnt_id, timeout, fin_err;
    logic [DATA_WIDTH-1:0] fin_rdata;

    // A requester is masked in its own done cycle so it cannot be re-granted on a stale valid.
    rr_arb2 u_arb (
        .eligible  ({r1_valid & ~r1_done_q, r0_valid & ~r0_done_q}),
        .last_grant(last_grant_q),
        .gnt_valid (gnt_valid),
        .gnt_id    (gnt_id)
    );

    assign timeout = (TIMEOUT_CYCLES > 0) && (cnt_q == CW'(TIMEOUT_CYCLES - 1));

    always_comb begin
        state_d      = state_q;
        psel_d       = psel_q;
        penable_d    = penable_q;
        pwrite_d     = pwrite_q;
        paddr_d      = paddr_q;
        pwdata_d     = pwdata_q;
        grant_d      = grant_q;
        busy_d       = busy_q;
        last_grant_d = last_grant_q;
        r0_done_d    = 1'b0;
        r1_done_d    = 1'b0;
        r0_err_d     = r0_err_q;
        r1_err_d     = r1_err_q;
        r0_rdata_d   = r0_rdata_q;
        r1_rdata_d   = r1_rdata_q;
        cnt_d        = cnt_q;
        fin_err      = PREADY ? PSLVERR : 1'b1;
        fin_rdata    = PREADY ? PRDATA : '0;
        case (state_q)
            APB_IDLE: if (gnt_valid) begin
                grant_d   = gnt_id;
                pwrite_d  = gnt_id ? r1_write : r0_write;
                paddr_d   = gnt_id ? r1_addr : r0_addr;
                pwdata_d  = gnt_id ? r1_wdata : r0_wdata;
                psel_d    = 1'b1;
                penable_d = 1'b0;
                busy_d    = 1'b1;
                state_d   = APB_SETUP;
            end
            APB_SETUP: begin
                penable_d = 1'b1;
                cnt_d     = '0;
                state_d   = APB_ACCESS;
            end
            APB_ACCESS: if (PREADY || timeout) begin
                psel_d       = 1'b0;
                penable_d    = 1'b0;
                busy_d       = 1'b0;
                last_grant_d = grant_q;
                state_d      = APB_IDLE;
                r0_done_d    = ~grant_q;
                r1_done_d    = grant_q;
                r0_err_d     = grant_q ? r0_err_q : fin_err;
                r1_err_d     = grant_q ? fin_err : r1_err_q;
                r0_rdata_d   = (grant_q || pwrite_q) ? r0_rdata_q : fin_rdata;
                r1_rdata_d   = (!grant_q || pwrite_q) ? r1_rdata_q : fin_rdata;
            end else begin
                cnt_d = (&cnt_q) ? cnt_q : cnt_q + CW'(1);
            end
            default: state_d = APB_IDLE;
        endcase
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state_q      <= APB_IDLE;
            psel_q       <= 1'b0;
            penable_q    <= 1'b0;
            pwrite_q     <= 1'b0;
            paddr_q      <= '0;
            pwdata_q     <= '0;
            grant_q      <= 1'b0;
            busy_q       <= 1'b0;
            last_grant_q <= 1'b1;
            r0_done_q    <= 1'b0;
            r1_done_q    <= 1'b0;
            r0_err_q     <= 1'b0;
            r1_err_q     <= 1'b0;
            r0_rdata_q   <= '0;
            r1_rdata_q   <= '0;
            cnt_q        <= '0;
        end else begin
            state_q      <= state_d;
            psel_q       <= psel_d;
            penable_q    <= penable_d;
            pwrite_q     <= pwrite_d;
            paddr_q      <= paddr_d;
            pwdata_q     <= pwdata_d;
            grant_q      <= grant_d;
            busy_q       <= busy_d;
            last_grant_q <= last_grant_d;
            r0_done_q    <= r0_done_d;
            r1_done_q    <= r1_done_d;
            r0_err_q     <= r0_err_d;
            r1_err_q     <= r1_err_d;
            r0_rdata_q   <= r0_rdata_d;
            r1_rdata_q   <= r1_rdata_d;
            cnt_q        <= cnt_d;
        end
    end

    assign PSEL     = psel_q;
    assign PENABLE  = penable_q;
    assign PWRITE   = pwrite_q;
    assign PADDR    = paddr_q;
    assign PWDATA   = pwdata_q;
    assign grant    = grant_q;
    assign busy     = busy_q;
    assign r0_done  = r0_done_q;
    assign r1_done  = r1_done_q;
    assign r0_err   = r0_err_q;
    assign r1_err   = r1_err_q;
    assign r0_rdata = r0_rdata_q;
    assign r1_rdata = r1_rdata_q;
endmodule
